// File: rtl/uart_rx_deser_pkg.sv
// uart_pkg: shared types and constants for the UART receive front end.
//   uart_rx_state_t   : receiver controller states
//   UART_OVERSAMPLE   : oversample ticks per bit
//   UART_SAMPLE_PHASE : phase (after the tick) at which a bit is sampled
//   UART_DATA_BITS    : data bits per character
//   maj3()            : 2-of-3 vote used when UART_RX_MAJORITY_EN is defined
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_rx_state_t;

   localparam int unsigned UART_OVERSAMPLE   = 32'd16;
   localparam int unsigned UART_SAMPLE_PHASE = 32'd8;
   localparam int unsigned UART_DATA_BITS    = 32'd8;
   localparam int unsigned PHASE_W           = $clog2(UART_OVERSAMPLE);
   localparam int unsigned BIT_IDX_W         = $clog2(UART_DATA_BITS);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_deser_if.sv
// uart_rx_deser_if: byte hand-off and status flags between the receive
// front end (master) and the UART register block (slave).
//   rx_data/rx_valid/rx_ready : valid/ready holding-register transfer
//   err_clr                   : clear pulse for both sticky flags
//   rx_frame_err/rx_overrun   : sticky status flags
interface uart_rx_deser_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       err_clr;
   logic       rx_frame_err;
   logic       rx_overrun;

   modport master (
      output rx_data, rx_valid, rx_frame_err, rx_overrun,
      input  rx_ready, err_clr
   );

   modport slave (
      input  rx_data, rx_valid, rx_frame_err, rx_overrun,
      output rx_ready, err_clr
   );
endinterface

// File: rtl/uart_rx_deser_baud_tick.sv
// uart_baud_tick: oversample tick generator.
//   clk_uart : clock          rst     : synchronous active-high reset
//   restart  : forces the count to 0 (start edge)
//   tick     : registered one-cycle pulse every TICK_DIV cycles
module uart_baud_tick #(
   parameter int unsigned TICK_DIV = 6
) (
   input  logic clk_uart,
   input  logic rst,
   input  logic restart,
   output logic tick
);
   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 32'd1);

   logic [15:0] cnt_r;
   logic [15:0] cnt_nxt_s;

   // next count: restart wins, otherwise wrap at TICK_LAST
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (restart) begin
         cnt_nxt_s = 16'd0;
      end else if (cnt_r == TICK_LAST) begin
         cnt_nxt_s = 16'd0;
      end else begin
         cnt_nxt_s = cnt_r + 16'd1;
      end
   end

   // counter and tick register; tick is high while the count sits at TICK_LAST
   always_ff @(posedge clk_uart) begin
      if (rst) begin
         cnt_r <= 16'd0;
         tick  <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         tick  <= (cnt_nxt_s == TICK_LAST);
      end
   end
endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1 UART receive front end with 16x oversampling.
//   clk_uart : only clock           rst   : synchronous active-high reset
//   rxd      : asynchronous serial input (idles high)
//   busy     : controller is not idle
//   rx_if    : master side of uart_rx_deser_if (byte hand-off and flags)
// Build option: define UART_RX_MAJORITY_EN to take each bit as the 2-of-3
// vote of the phase 7/8/9 samples (decisions move one tick later).
module uart_rx_deser
   import uart_pkg::*;
#(
   parameter int unsigned TICK_DIV = 6
) (
   input  logic            clk_uart,
   input  logic            rst,
   input  logic            rxd,
   output logic            busy,
   uart_rx_deser_if.master rx_if
);
   localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(UART_DATA_BITS - 32'd1);

   logic                      sync1_r, rxs_r;
   uart_rx_state_t            state_r, state_nxt_s;
   logic [PHASE_W-1:0]        phase_r, phase_inc_s;
   logic [BIT_IDX_W-1:0]      bit_idx_r, bit_idx_nxt_s;
   logic [UART_DATA_BITS-1:0] shift_r, shift_nxt_s;
   logic [7:0]                data_r;
   logic                      valid_r, ferr_r, ovr_r, busy_r;
   logic                      tick_s, restart_s, sample_s, bit_s;
   logic                      done_s, ferr_set_s, xfer_s, load_s, ovr_set_s;

   uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk_uart (clk_uart),
      .rst      (rst),
      .restart  (restart_s),
      .tick     (tick_s)
   );

   // phase seen after this tick's increment; sample points are defined on it
   assign phase_inc_s = phase_r + PHASE_W'(32'd1);

`ifdef UART_RX_MAJORITY_EN
   logic maj_a_r, maj_b_r;

   assign sample_s = tick_s && (phase_inc_s == PHASE_W'(UART_SAMPLE_PHASE + 32'd1));
   assign bit_s    = maj3(maj_a_r, maj_b_r, rxs_r);

   // capture the phase-7 and phase-8 samples for the vote taken on phase 9
   always_ff @(posedge clk_uart) begin
      if (rst) begin
         maj_a_r <= 1'b1;
         maj_b_r <= 1'b1;
      end else begin
         if (tick_s && (phase_inc_s == PHASE_W'(UART_SAMPLE_PHASE - 32'd1))) begin
            maj_a_r <= rxs_r;
         end
         if (tick_s && (phase_inc_s == PHASE_W'(UART_SAMPLE_PHASE))) begin
            maj_b_r <= rxs_r;
         end
      end
   end
`else
   assign sample_s = tick_s && (phase_inc_s == PHASE_W'(UART_SAMPLE_PHASE));
   assign bit_s    = rxs_r;
`endif

   // controller next state; bit decisions only happen on sample points
   always_comb begin
      state_nxt_s   = state_r;
      bit_idx_nxt_s = bit_idx_r;
      shift_nxt_s   = shift_r;
      restart_s     = 1'b0;
      done_s        = 1'b0;
      ferr_set_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (!rxs_r) begin
               state_nxt_s = START;
               restart_s   = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (sample_s) begin
               if (bit_s) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s   = DATA;
                  bit_idx_nxt_s = {BIT_IDX_W{1'b0}};
               end
            end else begin
               state_nxt_s = START;
            end
         end
         DATA: begin
            if (sample_s) begin
               // LSB arrives first, so shift in at the MSB
               shift_nxt_s = {bit_s, shift_r[UART_DATA_BITS-1:1]};
               if (bit_idx_r == LAST_BIT) begin
                  state_nxt_s = STOP;
               end else begin
                  bit_idx_nxt_s = bit_idx_r + BIT_IDX_W'(32'd1);
               end
            end else begin
               state_nxt_s = DATA;
            end
         end
         STOP: begin
            if (sample_s) begin
               state_nxt_s = IDLE;
               if (bit_s) begin
                  done_s = 1'b1;
               end else begin
                  ferr_set_s = 1'b1;
               end
            end else begin
               state_nxt_s = STOP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // holding register: a same-cycle transfer frees the slot for the new byte
   always_comb begin
      xfer_s    = valid_r && rx_if.rx_ready;
      load_s    = 1'b0;
      ovr_set_s = 1'b0;
      if (done_s) begin
         if (valid_r && !xfer_s) begin
            ovr_set_s = 1'b1;
         end else begin
            load_s = 1'b1;
         end
      end else begin
         load_s    = 1'b0;
         ovr_set_s = 1'b0;
      end
   end

   // synchroniser, controller state, phase counter and shift register
   always_ff @(posedge clk_uart) begin
      if (rst) begin
         sync1_r   <= 1'b1;
         rxs_r     <= 1'b1;
         state_r   <= IDLE;
         busy_r    <= 1'b0;
         phase_r   <= {PHASE_W{1'b0}};
         bit_idx_r <= {BIT_IDX_W{1'b0}};
         shift_r   <= {UART_DATA_BITS{1'b0}};
      end else begin
         sync1_r   <= rxd;
         rxs_r     <= sync1_r;
         state_r   <= state_nxt_s;
         busy_r    <= (state_nxt_s != IDLE);
         bit_idx_r <= bit_idx_nxt_s;
         shift_r   <= shift_nxt_s;
         if (restart_s) begin
            phase_r <= {PHASE_W{1'b0}};
         end else if (tick_s) begin
            phase_r <= phase_inc_s;
         end
      end
   end

   // holding register and sticky flags; a set event beats err_clr
   always_ff @(posedge clk_uart) begin
      if (rst) begin
         data_r  <= 8'd0;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         ovr_r   <= 1'b0;
      end else begin
         if (load_s) begin
            data_r  <= shift_r;
            valid_r <= 1'b1;
         end else if (xfer_s) begin
            valid_r <= 1'b0;
         end
         if (ferr_set_s) begin
            ferr_r <= 1'b1;
         end else if (rx_if.err_clr) begin
            ferr_r <= 1'b0;
         end
         if (ovr_set_s) begin
            ovr_r <= 1'b1;
         end else if (rx_if.err_clr) begin
            ovr_r <= 1'b0;
         end
      end
   end

   assign rx_if.rx_data      = data_r;
   assign rx_if.rx_valid     = valid_r;
   assign rx_if.rx_frame_err = ferr_r;
   assign rx_if.rx_overrun   = ovr_r;
   assign busy               = busy_r;
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: self-checking bench for uart_rx_deser (TICK_DIV = 6).
// Every pin level is logged per clock edge; expected bytes and event cycles
// are derived by sampling that log at the bit-centre tick positions.
module tb_uart_rx_deser;
   localparam int T   = 6;
   localparam int BIT = 16 * T;
`ifdef UART_RX_MAJORITY_EN
   localparam int KOFS = 1;
`else
   localparam int KOFS = 0;
`endif
   localparam int KDEC   = 152 + KOFS;
   localparam int KSTART = 8 + KOFS;

   logic clk_uart = 1'b0;
   logic rst;
   logic rxd;
   logic busy;

   uart_rx_deser_if rx_if ();

   uart_rx_deser #(.TICK_DIV(T)) dut (
      .clk_uart (clk_uart),
      .rst      (rst),
      .rxd      (rxd),
      .busy     (busy),
      .rx_if    (rx_if)
   );

   always #5 clk_uart = ~clk_uart;

   int   cyc;
   logic pin_hist [0:65535];
   int   valid_rise, ferr_rise, ovr_rise;
   logic last_valid, last_ferr, last_ovr;
   int   ready_at, clr_at;
   logic rdy_force, clr_force, rst_v;
   int   n_checks, n_pass;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one clock of inputs, log the pin, then observe at the falling edge.
   task automatic step(input logic v);
      rxd            = v;
      rst            = rst_v;
      rx_if.rx_ready = rdy_force || (cyc == ready_at);
      rx_if.err_clr  = clr_force || (cyc == clr_at);
      @(posedge clk_uart);
      cyc++;
      pin_hist[cyc] = v;
      @(negedge clk_uart);
      if (rx_if.rx_valid && !last_valid)   valid_rise = cyc;
      if (rx_if.rx_frame_err && !last_ferr) ferr_rise = cyc;
      if (rx_if.rx_overrun && !last_ovr)   ovr_rise  = cyc;
      last_valid = rx_if.rx_valid;
      last_ferr  = rx_if.rx_frame_err;
      last_ovr   = rx_if.rx_overrun;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) step(1'b1);
   endtask

   // 8N1 frame; pins in [dis_lo, dis_hi) (offsets from the start edge) inverted
   task automatic send_frame(input logic [7:0] d, input logic stop, input int dis_lo,
                             input int dis_hi, input logic rdy_dec, input logic clr_dec,
                             output int p);
      int   j;
      logic v;
      valid_rise = -1;
      ferr_rise  = -1;
      ovr_rise   = -1;
      p          = 0;
      for (int t = 0; t < 10 * BIT; t++) begin
         j = t / BIT;
         if (j == 0)      v = 1'b0;
         else if (j <= 8) v = d[3'(j - 1)];
         else             v = stop;
         if (t >= dis_lo && t < dis_hi) v = ~v;
         step(v);
         if (t == 0) begin
            p = cyc;
            if (rdy_dec) ready_at = p + 1 + KDEC * T;
            if (clr_dec) clr_at   = p + 1 + KDEC * T;
         end
      end
      ready_at = -1;
      clr_at   = -1;
   endtask

   // value the receiver should take for the bit whose centre is tick k
   function automatic logic samp(input int p, input int k);
`ifdef UART_RX_MAJORITY_EN
      int ones;
      ones = int'(pin_hist[p + (k - 1) * T]) + int'(pin_hist[p + k * T])
           + int'(pin_hist[p + (k + 1) * T]);
      return (ones >= 2);
`else
      return pin_hist[p + k * T];
`endif
   endfunction

   task automatic model_frame(input int p, output logic [7:0] md, output logic stop_ok);
      for (int i = 0; i < 8; i++) md[i] = samp(p, 8 + 16 * (i + 1));
      stop_ok = samp(p, 152);
   endtask

   task automatic pulse_ready();
      rdy_force = 1'b1;
      step(1'b1);
      rdy_force = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_force = 1'b1;
      step(1'b1);
      clr_force = 1'b0;
   endtask

   initial begin
      int         p, p2;
      logic [7:0] md;
      logic       sto;
      cyc = 0; n_checks = 0; n_pass = 0;
      ready_at = -1; clr_at = -1;
      rdy_force = 1'b0; clr_force = 1'b0; rst_v = 1'b1;
      last_valid = 1'b0; last_ferr = 1'b0; last_ovr = 1'b0;
      rst = 1'b1; rxd = 1'b1; rx_if.rx_ready = 1'b0; rx_if.err_clr = 1'b0;
      @(negedge clk_uart);

      // reset
      repeat (3) step(1'b1);
      chk_val("rst_valid", rx_if.rx_valid, 0);
      chk_val("rst_data", rx_if.rx_data, 0);
      chk_val("rst_ferr", rx_if.rx_frame_err, 0);
      chk_val("rst_ovr", rx_if.rx_overrun, 0);
      chk_val("rst_busy", busy, 0);
      rst_v = 1'b0;
      idle_cycles(20);

      // good byte, held until accepted
      send_frame(8'hA5, 1'b1, 0, 0, 1'b0, 1'b0, p);
      idle_cycles(100);
      chk_val("good_latency", valid_rise - (p + 1), 152 * T + 1 + KOFS * T);
      chk_val("good_data", rx_if.rx_data, 8'hA5);
      chk_val("good_held", rx_if.rx_valid, 1);
      pulse_ready();
      chk_val("good_taken", rx_if.rx_valid, 0);
      chk_val("good_data_stable", rx_if.rx_data, 8'hA5);

      // start glitch of 30 cycles
      for (int t = 0; t <= KSTART * T + 1; t++) begin
         step((t < 30) ? 1'b0 : 1'b1);
         if (t == 0) p = cyc;
      end
      chk_val("glitch_busy_hi", busy, 1);
      step(1'b1);
      chk_val("glitch_busy_lo", busy, 0);
      idle_cycles(20);
      chk_val("glitch_valid", rx_if.rx_valid, 0);
      chk_val("glitch_ferr", rx_if.rx_frame_err, 0);
      chk_val("glitch_ovr", rx_if.rx_overrun, 0);

      // framing error, clear, then clear colliding with the set
      send_frame(8'h3C, 1'b0, 0, 0, 1'b0, 1'b0, p);
      idle_cycles(150);
      chk_val("ferr_rise", ferr_rise, p + KDEC * T + 2);
      chk_val("ferr_valid", rx_if.rx_valid, 0);
      pulse_clr();
      chk_val("ferr_cleared", rx_if.rx_frame_err, 0);
      send_frame(8'h3C, 1'b0, 0, 0, 1'b0, 1'b1, p);
      idle_cycles(150);
      chk_val("ferr_set_wins", rx_if.rx_frame_err, 1);
      chk_val("ferr_rise2", ferr_rise, p + KDEC * T + 2);
      pulse_clr();

      // overrun: two bytes back to back, nobody reading
      send_frame(8'h11, 1'b1, 0, 0, 1'b0, 1'b0, p);
      send_frame(8'h22, 1'b1, 0, 0, 1'b0, 1'b0, p2);
      idle_cycles(100);
      chk_val("ovr_data", rx_if.rx_data, 8'h11);
      chk_val("ovr_flag", rx_if.rx_overrun, 1);
      chk_val("ovr_rise", ovr_rise, p2 + KDEC * T + 2);
      chk_val("ovr_valid", rx_if.rx_valid, 1);
      pulse_ready();
      pulse_clr();
      chk_val("ovr_cleared", rx_if.rx_overrun, 0);

      // same pair, reader accepts in the load cycle of the second byte
      send_frame(8'h11, 1'b1, 0, 0, 1'b0, 1'b0, p);
      send_frame(8'h22, 1'b1, 0, 0, 1'b1, 1'b0, p2);
      idle_cycles(100);
      chk_val("swap_data", rx_if.rx_data, 8'h22);
      chk_val("swap_valid", rx_if.rx_valid, 1);
      chk_val("swap_no_ovr", rx_if.rx_overrun, 0);
      pulse_ready();

      // 6-cycle inversion centred on data bit 3
      send_frame(8'hFF, 1'b1, 72 * T - 3, 72 * T + 3, 1'b0, 1'b0, p);
      idle_cycles(100);
`ifdef UART_RX_MAJORITY_EN
      chk_val("maj_data", rx_if.rx_data, 8'hFF);
`else
      chk_val("maj_data", rx_if.rx_data, 8'hF7);
`endif
      pulse_ready();

      // random bytes, stop bits and disturbance windows against the pin model
      for (int n = 0; n < 8; n++) begin
         logic [7:0] d;
         logic       stop;
         int         lo, len;
         d    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         lo   = BIT + int'($urandom_range(0, 8 * BIT - 13));
         len  = int'($urandom_range(0, 12));
         send_frame(d, stop, lo, lo + len, 1'b0, 1'b0, p);
         idle_cycles(150);
         model_frame(p, md, sto);
         if (sto) begin
            chk_val("rnd_valid_rise", valid_rise, p + KDEC * T + 2);
            chk_val("rnd_data", rx_if.rx_data, md);
            chk_val("rnd_no_ferr", rx_if.rx_frame_err, 0);
            pulse_ready();
            chk_val("rnd_taken", rx_if.rx_valid, 0);
         end else begin
            chk_val("rnd_ferr_rise", ferr_rise, p + KDEC * T + 2);
            chk_val("rnd_no_valid", rx_if.rx_valid, 0);
            pulse_clr();
            chk_val("rnd_ferr_clr", rx_if.rx_frame_err, 0);
         end
      end

      // reset in the middle of a character
      for (int t = 0; t < 300; t++) step((t < BIT) ? 1'b0 : 1'b1);
      chk_val("mid_busy_pre", busy, 1);
      rst_v = 1'b1;
      step(1'b1);
      chk_val("mid_busy", busy, 0);
      rst_v = 1'b0;
      idle_cycles(1200);
      chk_val("mid_valid", rx_if.rx_valid, 0);
      chk_val("mid_ferr", rx_if.rx_frame_err, 0);
      chk_val("mid_ovr", rx_if.rx_overrun, 0);
      chk_val("mid_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
